// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester front end for a shared combinational ALU.
// It arbitrates between requesters, registers the winning operands toward the
// ALU, captures the ALU result one cycle later, and holds it as a response
// until the consumer takes it.
// Define ALU_ARB_RR_EN to select round-robin arbitration on ties. Without it,
// requester 0 has fixed priority.
module alu_arbiter (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [63:0] req_a,
    input  logic [63:0] req_b,
    input  logic [5:0]  req_ctl,
    input  logic [9:0]  req_shamt,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [2:0]  alu_ctl,
    output logic [4:0]  alu_shamt,
    input  logic [31:0] alu_y,
    input  logic        alu_zero,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [31:0] rsp_y,
    output logic        rsp_zero
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_RESP
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic   w_can_accept;
    logic   w_accept;
    logic   w_grant;
    logic   r_pend_id;

`ifdef ALU_ARB_RR_EN
    logic   r_prio;     // requester that wins the next tie
`endif

    // Winner selection: a lone requester always wins; ties use priority scheme
    always_comb begin
        w_grant = 1'b0;
        case (req_valid)
            2'b01:   w_grant = 1'b0;
            2'b10:   w_grant = 1'b1;
`ifdef ALU_ARB_RR_EN
            2'b11:   w_grant = r_prio;
`else
            2'b11:   w_grant = 1'b0;
`endif
            default: w_grant = 1'b0;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, accept decision and handshake outputs
    always_comb begin
        w_state_nxt  = r_state;
        w_can_accept = 1'b0;
        case (r_state)
            ST_IDLE: w_can_accept = 1'b1;
            ST_RESP: w_can_accept = rsp_ready;
            default: w_can_accept = 1'b0;
        endcase

        // reset_n gates the handshake so nothing is granted while reset is held
        w_accept  = w_can_accept & reset_n & (|req_valid);
        req_ready = w_accept ? (w_grant ? 2'b10 : 2'b01) : 2'b00;

        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                w_state_nxt = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    w_state_nxt = w_accept ? ST_EXEC : ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Issue registers: load winner's operation on accept, otherwise hold
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            alu_a     <= '0;
            alu_b     <= '0;
            alu_ctl   <= '0;
            alu_shamt <= '0;
            r_pend_id <= 1'b0;
        end else if (w_accept) begin
            alu_a     <= w_grant ? req_a[63:32]    : req_a[31:0];
            alu_b     <= w_grant ? req_b[63:32]    : req_b[31:0];
            alu_ctl   <= w_grant ? req_ctl[5:3]    : req_ctl[2:0];
            alu_shamt <= w_grant ? req_shamt[9:5]  : req_shamt[4:0];
            r_pend_id <= w_grant;
        end
    end

    // Response registers: capture ALU in EXEC, retire on consumer handshake.
    // rsp_id is taken from the pending owner in EXEC rather than at accept, so
    // a new accept while the previous response retires cannot disturb it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_y     <= '0;
            rsp_zero  <= 1'b0;
        end else if (r_state == ST_EXEC) begin
            rsp_valid <= 1'b1;
            rsp_id    <= r_pend_id;
            rsp_y     <= alu_y;
            rsp_zero  <= alu_zero;
        end else if ((r_state == ST_RESP) && rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

`ifdef ALU_ARB_RR_EN
    // Tie-break pointer: after serving requester i, favour the other one
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_prio <= 1'b0;
        end else if (w_accept) begin
            r_prio <= ~w_grant;
        end
    end
`endif

    // Handshake sanity: at most one grant, and a stalled response stays put
    a_one_grant: assert property (@(posedge clk) disable iff (!reset_n)
        $onehot0(req_ready));

    a_rsp_hold: assert property (@(posedge clk) disable iff (!reset_n)
        (rsp_valid && !rsp_ready) |=>
            (rsp_valid && $stable(rsp_y) && $stable(rsp_id) && $stable(rsp_zero)));

endmodule
